// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
// Holds the scan FSM states, the raw "all segments off" pattern and the polarity helper.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_e;

    // Raw active-high pattern with every segment dark.
    localparam logic [7:0] SEG_OFF = 8'h00;

    function automatic logic [7:0] seg_drive(
        input logic [7:0] raw,
        input logic       active_low
    );
        return active_low ? ~raw : raw;
    endfunction

endpackage

// File: rtl/seg_next_idx.sv
// Round-robin finder: next set bit of mask strictly after cur, wrapping.
// wrap flags a result at or below cur; any flags a non-empty mask.
module seg_next_idx #(
    parameter int NUM_DIGITS = 4,
    parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic [NUM_DIGITS-1:0] mask,
    input  logic [IDX_W-1:0]      cur,
    output logic [IDX_W-1:0]      idx,
    output logic                  wrap,
    output logic                  any
);

    // Walk candidates from farthest to nearest so the nearest set bit wins.
    always_comb begin
        int                j;
        logic [IDX_W-1:0]  cand;
        j    = 0;
        cand = '0;
        idx  = '0;
        any  = |mask;
        for (int k = NUM_DIGITS; k >= 1; k--) begin
            j    = (int'(cur) + k) % NUM_DIGITS;
            cand = IDX_W'(j);
            if (mask[cand]) begin
                idx = cand;
            end
        end
        wrap = any && (idx <= cur);
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-division scan of NUM_DIGITS 7-segment digits over one shared segment bus.
// Each slot is a blanked dead-time followed by a latched ON phase; masked digits are skipped.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int TICK_DIV       = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    localparam int IDX_W         = $clog2(NUM_DIGITS),
    localparam int CNT_W         = $clog2(TICK_DIV)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_DIGITS-1:0]     digit_mask,
    input  logic [NUM_DIGITS*8-1:0]   seg_data,
    output logic [NUM_DIGITS-1:0]     sel,
    output logic [7:0]                seg,
    output logic [IDX_W-1:0]          digit_idx,
    output logic                      frame_start
);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic             SEL_LOW    = (SEL_ACTIVE_LOW != 0);
    localparam logic             SEG_LOW    = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] SEL_IDLE = {NUM_DIGITS{SEL_LOW}};
    localparam logic [7:0]       SEG_IDLE   = seg_drive(SEG_OFF, SEG_LOW);
    localparam logic [IDX_W-1:0] TOP_IDX    = IDX_W'(NUM_DIGITS - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic                    first_q, first_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [7:0]              seg_q, seg_d;
    logic                    fs_q, fs_d;

    logic [IDX_W-1:0]        srch_cur;
    logic [IDX_W-1:0]        nxt_idx;
    logic                    nxt_any;
    logic                    unused_wrap;
    logic [NUM_DIGITS-1:0]   onehot;

    // From IDLE, searching after the top index yields the lowest set bit.
    assign srch_cur = (state_q == IDLE) ? TOP_IDX : idx_q;

    seg_next_idx #(
        .NUM_DIGITS (NUM_DIGITS),
        .IDX_W      (IDX_W)
    ) u_next (
        .mask (digit_mask),
        .cur  (srch_cur),
        .idx  (nxt_idx),
        .wrap (unused_wrap),
        .any  (nxt_any)
    );

    // Scan FSM: slot counter, digit pointer and the registered pin values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        first_d = first_q;
        sel_d   = SEL_IDLE;
        seg_d   = SEG_IDLE;
        fs_d    = 1'b0;
        onehot  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = nxt_any ? nxt_idx : '0;
                    first_d = 1'b1;
                end
            end
            BLANK: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == BLANK_LAST) begin
                    if (digit_mask[idx_q]) begin
                        state_d = ON;
                        cnt_d   = cnt_q + 1'b1;
                        sel_d   = onehot ^ SEL_IDLE;
                        seg_d   = seg_drive(seg_data[8*idx_q +: 8], SEG_LOW);
                        fs_d    = first_q || (idx_q <= last_q);
                        first_d = 1'b0;
                        last_d  = idx_q;
                    end else begin
                        cnt_d = '0;
                        idx_d = nxt_any ? nxt_idx : idx_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ON: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == SLOT_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = nxt_any ? nxt_idx : idx_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    sel_d = sel_q;
                    seg_d = seg_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            first_q <= 1'b0;
            sel_q   <= SEL_IDLE;
            seg_q   <= SEG_IDLE;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            first_q <= first_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            fs_q    <= fs_d;
        end
    end

    assign sel         = sel_q;
    assign seg         = seg_q;
    assign digit_idx   = idx_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed scoreboard bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2 blank).
// Expected pin values per cycle are queued with the stimulus and popped each clock.
module tb_seg_scan_ctrl;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] seg;
        logic       fs;
        logic       chk_idx;
        logic [1:0] idx;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  digit_mask;
    logic [31:0] seg_data;
    logic [3:0]  sel;
    logic [7:0]  seg;
    logic [1:0]  digit_idx;
    logic        frame_start;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS     (4),
        .TICK_DIV       (8),
        .BLANK_CYCLES   (2),
        .SEL_ACTIVE_LOW (1),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .digit_mask  (digit_mask),
        .seg_data    (seg_data),
        .sel         (sel),
        .seg         (seg),
        .digit_idx   (digit_idx),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h at %0t",
                    tag, got, exp, $time);
    endtask

    task automatic push(input logic [3:0] s, input logic [7:0] g,
                        input logic f, input logic ci,
                        input logic [1:0] ix);
        exp_t e;
        e.sel     = s;
        e.seg     = g;
        e.fs      = f;
        e.chk_idx = ci;
        e.idx     = ix;
        q.push_back(e);
    endtask

    // Blank phase of digit d (2 cycles) then n_on ON cycles showing raw.
    task automatic push_slot(input int d, input logic [7:0] raw,
                             input logic fs, input int n_on);
        logic [3:0] oh;
        oh = 4'b0001 << d;
        for (int i = 0; i < 2; i++) push(4'hF, 8'hFF, 1'b0, 1'b1, 2'(d));
        for (int i = 0; i < n_on; i++)
            push(~oh, ~raw, fs && (i == 0), 1'b1, 2'(d));
    endtask

    task automatic push_on(input int d, input logic [7:0] raw,
                           input logic fs, input int n_on);
        logic [3:0] oh;
        oh = 4'b0001 << d;
        for (int i = 0; i < n_on; i++)
            push(~oh, ~raw, fs && (i == 0), 1'b1, 2'(d));
    endtask

    task automatic push_dark(input int n);
        for (int i = 0; i < n; i++) push(4'hF, 8'hFF, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic step(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                chk("scoreboard_empty", 8'd0, 8'd1);
            end else begin
                e = q.pop_front();
                chk("sel", {4'h0, sel}, {4'h0, e.sel});
                chk("seg", seg, e.seg);
                chk("frame_start", {7'h0, frame_start}, {7'h0, e.fs});
                if (e.chk_idx)
                    chk("digit_idx", {6'h0, digit_idx}, {6'h0, e.idx});
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        digit_mask = 4'b1111;
        seg_data   = {8'h4F, 8'h5B, 8'h06, 8'h3F};

        // Reset values.
        for (int i = 0; i < 2; i++) push(4'hF, 8'hFF, 1'b0, 1'b1, 2'd0);
        step(2);

        // Frame 1: full mask, startup frame_start on digit 0.
        rst = 1'b0;
        en  = 1'b1;
        push_slot(0, 8'h3F, 1'b1, 6);
        push_slot(1, 8'h06, 1'b0, 6);
        push_slot(2, 8'h5B, 1'b0, 6);
        push_slot(3, 8'h4F, 1'b0, 6);
        step(32);

        // Frame 2: digit 1 data changes mid-ON, display holds old pattern.
        push_slot(0, 8'h3F, 1'b1, 6);
        push_slot(1, 8'h06, 1'b0, 6);
        step(8 + 2 + 3);
        seg_data[15:8] = 8'h77;
        push_slot(2, 8'h5B, 1'b0, 6);
        push_slot(3, 8'h4F, 1'b0, 6);
        step(3 + 16);

        // Frame 3: new data shown; digit 1 masked mid-ON, slot completes.
        push_slot(0, 8'h3F, 1'b1, 6);
        push_slot(1, 8'h77, 1'b0, 6);
        step(8 + 2 + 2);
        digit_mask = 4'b1101;
        push_slot(2, 8'h5B, 1'b0, 6);
        push_slot(3, 8'h4F, 1'b0, 6);
        step(4 + 16);

        // Frame 4: digit 1 skipped; mask narrowed to 0101 during digit 0.
        push_slot(0, 8'h3F, 1'b1, 6);
        push_slot(2, 8'h5B, 1'b0, 6);
        step(2 + 1);
        digit_mask = 4'b0101;
        step(5 + 8);

        // Frames 5-6: digits 0 and 2 alternate, 16-cycle frame.
        push_slot(0, 8'h3F, 1'b1, 6);
        push_slot(2, 8'h5B, 1'b0, 6);
        push_slot(0, 8'h3F, 1'b1, 6);
        push_slot(2, 8'h5B, 1'b0, 6);
        step(16 + 8 + 2 + 3);

        // Empty mask: selects stay inactive.
        digit_mask = 4'b0000;
        push_dark(20);
        step(3 + 20);

        // Mask restored while blanking digit 2: it re-displays and wraps.
        digit_mask = 4'b1111;
        push_on(2, 8'h5B, 1'b1, 6);
        push_slot(3, 8'h4F, 1'b0, 6);
        push_slot(0, 8'h3F, 1'b1, 6);
        push_slot(1, 8'h77, 1'b0, 3);
        step(6 + 8 + 8 + 5);

        // Enable dropped mid-ON, then re-enabled.
        en = 1'b0;
        push_dark(3);
        step(3);
        en = 1'b1;
        push_slot(0, 8'h3F, 1'b1, 6);
        push_slot(1, 8'h77, 1'b0, 6);
        push_slot(2, 8'h5B, 1'b0, 3);
        step(8 + 8 + 5);

        // Reset mid-ON of digit 2 with en still high.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) push(4'hF, 8'hFF, 1'b0, 1'b1, 2'd0);
        step(2);

        chk("queue_drained", 8'(q.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed 7-segment display scan controller: time-division drives `NUM_DIGITS` common-anode/cathode digits from one shared segment bus. It generates its own per-digit slot timing from the system clock and inserts a dead-time blanking interval between digits to suppress ghosting. It skips masked digits and latches each digit's segment pattern for its whole slot. It sits between the clock/counter datapath, which supplies packed segment patterns, and the board's digit-select and segment pins.

## Interface
- `NUM_DIGITS`, 4: digits scanned, 2..8.
- `TICK_DIV`, 50000: clock cycles per digit slot (blank plus on).
- `BLANK_CYCLES`, 16: dead-time cycles at slot start. Constraints: 1 ≤ `BLANK_CYCLES` < `TICK_DIV`.
- `SEL_ACTIVE_LOW`, 1: select polarity. 1 means the active digit is driven 0.
- `SEG_ACTIVE_LOW`, 1: segment polarity on `seg`.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: scanning enable.
- `digit_mask` in `NUM_DIGITS`: 1 = digit participates in the scan.
- `seg_data` in `NUM_DIGITS*8`: digit i in bits [8i+7:8i] = {dp,g,f,e,d,c,b,a}, active-high.
- `sel` out `NUM_DIGITS`: digit selects, one-hot active or all inactive.
- `seg` out 8: segment drive, polarity per `SEG_ACTIVE_LOW`.
- `digit_idx` out `$clog2(NUM_DIGITS)`: index of the current or next digit.
- `frame_start` out 1: one-cycle pulse at the start of each scan frame.

## Operation
- States: IDLE, BLANK, ON. All outputs are registered.
- Reset values: state IDLE, `digit_idx`=0, internal slot counter=0, `sel` all inactive, `seg`=off pattern, `frame_start`=0.
- IDLE: `sel` inactive, `seg` off. When `en`=1, go to BLANK with `digit_idx` = lowest set bit of `digit_mask` (0 if the mask is zero), counter=0.
- BLANK: `sel` inactive, `seg` off, for `BLANK_CYCLES` cycles. Exit rules:
  - Mask bit of `digit_idx` set at the last BLANK cycle: go to ON.
  - Mask bit clear at that point: restart BLANK on the next enabled digit.
  - Mask all zero: remain in BLANK with no select ever asserted.
- ON: `sel[digit_idx]` active. `seg` shows the pattern captured from `seg_data` at ON entry; it is held for the whole ON phase, with no tearing. ON lasts `TICK_DIV-BLANK_CYCLES` cycles, then go to BLANK with `digit_idx` = next set mask bit searched from `digit_idx+1` upward, wrapping modulo `NUM_DIGITS`. A single enabled digit re-selects itself.
- `digit_mask` is evaluated only at slot boundaries. Masking the current digit mid-ON does not cut that slot short.
- `frame_start` pulses on the first ON cycle when either:
  - the new index ≤ the previously displayed index (wrap), or
  - it is the first ON since leaving IDLE.
- `en` falling: next edge goes to IDLE; `sel` and `seg` are inactive and off from that edge.
- `rst` asserted in any state: next edge applies the reset values. `rst` has priority over `en`.

## Timing
- Steady-state slot period is exactly `TICK_DIV` cycles. Frame period is `TICK_DIV` × popcount(`digit_mask`).
- Startup: `en`=1 sampled at edge t (from IDLE) → BLANK from t. First `sel` assertion at edge t+`BLANK_CYCLES`.
- `seg_data` sampled once per slot, at the edge entering ON. Changes during ON appear in the next slot of that digit.
- Two selects are never active in the same cycle. `sel` is inactive for ≥ `BLANK_CYCLES` cycles between any two active periods.
- Counter width is `$clog2(TICK_DIV)`. The counter compares against `BLANK_CYCLES-1` and `TICK_DIV-1`, with no overflow.

## Structure
- Package `seg_scan_pkg`:
  - state enum typedef (IDLE/BLANK/ON),
  - `SEG_OFF` constant,
  - function applying the polarity parameters.
- Sub-module `seg_next_idx`: combinational round-robin finder of the next set bit of `digit_mask` after a given index, with wrap. It outputs the index, a wrap flag and an any-set flag.

## Test plan
All scenarios use `NUM_DIGITS`=4, `TICK_DIV`=8, `BLANK_CYCLES`=2, active-low polarities.
- Reset then `en`=1, mask 4'b1111, `seg_data` digits 0x3F/0x06/0x5B/0x4F → `sel` sequence 1110,1101,1011,0111.
  - Each select active for 6 cycles, separated by 2 cycles of 1111.
  - `seg` = ~0x3F, ~0x06, ~0x5B, ~0x4F.
  - `frame_start` once per 32 cycles.
- Mask 4'b0101 → only digits 0 and 2 alternate, slot 8 cycles, frame 16 cycles. Mask 4'b0000 → `sel` stays 1111 indefinitely.
- Change digit 1 data mid-ON → `seg` unchanged until digit 1's next slot.
- Deassert `en` mid-ON → next edge `sel`=1111 and `seg`=8'hFF. Reassert `en` → first select after exactly 2 cycles, `frame_start` pulses.
- Assert `rst` mid-ON of digit 2 → next edge all outputs at reset values, `digit_idx`=0.
- Clear digit 1's mask bit during its ON slot → slot completes full 6 cycles, digit 1 skipped from the next frame.
